// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive channel.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [3:0] ADDR_PAR_EN  = 4'd0;
  localparam logic [3:0] ADDR_PAR_ODD = 4'd1;
  localparam logic [3:0] ADDR_STOP2   = 4'd2;
  localparam logic [3:0] ADDR_FLEN    = 4'd3;
  localparam logic [3:0] ADDR_OVR_CLR = 4'd4;

  typedef struct packed {
    logic       par_en;
    logic       par_odd;
    logic       stop2;
    logic [3:0] flen;
  } rx_cfg_t;

  localparam rx_cfg_t RST_CFG = '{par_en: 1'b0, par_odd: 1'b0, stop2: 1'b0, flen: 4'd8};

  function automatic logic flen_ok(input logic [3:0] v, input int max_bits);
    return (v >= 4'd5) && (int'(v) <= max_bits);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive frame queue: DEPTH entries, wrapping pointers, occupancy count.
// When empty the head output keeps showing the most recently popped entry.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int W     = 11,
  parameter int DEPTH = 8
) (
  input  logic         clk_16bd,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  last_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full queue needs
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk_16bd) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_channel.sv
// Oversampling UART receiver with config registers and a receive queue.
// UART_RX_FIFO_EN selects a FIFO_DEPTH queue; otherwise a single holding register.
module uart_rx_channel
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int OSR           = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk_16bd,
  input  logic                     rst,
  input  logic                     Rx,
  input  logic                     valid,
  input  logic [3:0]               data,
  input  logic [3:0]               address,
  output logic                     ack,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [MAX_DATA_BITS-1:0] rd_data,
  output logic                     rd_perr,
  output logic                     rd_ferr,
  output logic                     overrun,
  output logic                     busy
);

`ifdef UART_RX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int DEPTH = FIFO_EN ? FIFO_DEPTH : 1;
  localparam int CW    = $clog2(OSR);
  localparam int W     = MAX_DATA_BITS + 2;

  logic [1:0]               rx_sync;
  logic                     rx_s;
  rx_cfg_t                  cfg_q, sh_q;
  logic                     ack_q, wr_en, ovr_q;
  rx_state_e                state_q, state_d;
  logic [CW-1:0]            cnt_q;
  logic [3:0]               bit_idx_q;
  logic                     stop_idx_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic                     perr_q, ferr_q;
  logic                     mid_start, bit_end, push_req, pop, full, empty, drop;
  logic [W-1:0]             push_data, head;

  always_ff @(posedge clk_16bd) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], Rx};
  end
  assign rx_s = rx_sync[1];

  // config port: accept when ack is low, so a held valid writes every other cycle
  assign wr_en = valid && !ack_q;

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      cfg_q <= RST_CFG;
      ack_q <= 1'b0;
    end else begin
      ack_q <= wr_en;
      if (wr_en) begin
        case (address)
          ADDR_PAR_EN:  cfg_q.par_en  <= data[0];
          ADDR_PAR_ODD: cfg_q.par_odd <= data[0];
          ADDR_STOP2:   cfg_q.stop2   <= data[0];
          ADDR_FLEN:    if (flen_ok(data, MAX_DATA_BITS)) cfg_q.flen <= data;
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_16bd) begin
    if (rst)                                    ovr_q <= 1'b0;
    else if (drop)                              ovr_q <= 1'b1;
    else if (wr_en && address == ADDR_OVR_CLR) ovr_q <= 1'b0;
  end

  assign mid_start = (cnt_q == CW'(OSR / 2 - 1));
  assign bit_end   = (cnt_q == CW'(OSR - 1));

  always_ff @(posedge clk_16bd) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      ST_IDLE:   if (!rx_s) state_d = ST_START;
      ST_START:  if (mid_start) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && bit_idx_q == sh_q.flen - 4'd1)
                   state_d = sh_q.par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end && (stop_idx_q || !sh_q.stop2)) begin
                   push_req = 1'b1;
                   state_d  = ST_IDLE;
                 end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      sh_q       <= RST_CFG;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q      <= '0;
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          // snapshot config so writes during a frame take effect on the next one
          if (!rx_s) begin
            sh_q   <= cfg_q;
            data_q <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
          end
        end
        ST_START: cnt_q <= mid_start ? '0 : cnt_q + 1'b1;
        default: begin
          cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
          if (bit_end) begin
            if (state_q == ST_DATA) begin
              data_q[bit_idx_q] <= rx_s;
              bit_idx_q         <= bit_idx_q + 1'b1;
            end
            if (state_q == ST_PARITY)
              perr_q <= (rx_s != ((^data_q) ^ sh_q.par_odd));
            if (state_q == ST_STOP) begin
              if (!rx_s) ferr_q <= 1'b1;
              stop_idx_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // the final stop sample is folded in directly since the push happens on that cycle
  assign push_data = {data_q, perr_q, ferr_q | ~rx_s};
  assign pop       = rd_ready && rd_valid;
  assign drop      = push_req && full && !pop;

  uart_rx_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk_16bd  (clk_16bd),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign {rd_data, rd_perr, rd_ferr} = head;
  assign rd_valid = !empty;
  assign ack      = ack_q;
  assign overrun  = ovr_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
